w4823_fir_seq: RTL and testbench

Tap sequencer and coefficient-load arbiter for the W4823 FIR MAC datapath, running in the fast clock domain.
- On each input-sample tick it writes the new FP16 sample into a circular delay line.
- It then sweeps all taps, driving coefficient and delay-line read addresses plus MAC control strobes, and flags output valid after the MAC pipeline drains.
- Between sweeps it arbitrates host coefficient writes into CMEM.

---
 rtl/w4823_fir_seq.sv | 197 +++++++++++++++++++
 tb/tb_w4823_fir_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w4823_fir_seq.sv
// Tap sequencer for the W4823 FIR MAC: writes each new sample into a circular
// delay line, sweeps all taps through the MAC, and lets host coefficient writes into CMEM between sweeps.
module w4823_fir_seq #(
    parameter int NTAPS    = 65,
    parameter int CADDR_W  = 7,
    parameter int DADDR_W  = 7,
    parameter int PIPE_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq_en,
    input  logic               sample_tick,
    input  logic [15:0]        din,
    input  logic               h_cvalid,
    input  logic [CADDR_W-1:0] h_caddr,
    input  logic [15:0]        h_cdata,
    output logic               h_cready,
    input  logic               err_clr,
    output logic               cmem_we,
    output logic [CADDR_W-1:0] cmem_addr,
    output logic [15:0]        cmem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [15:0]        dmem_wdata,
    output logic               mac_en,
    output logic               mac_clr,
    output logic               mac_last,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun_err,
    output logic               caddr_err
);

    localparam int DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int DRN_LAST_I = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

    localparam logic [CADDR_W-1:0] K_LAST   = CADDR_W'(NTAPS - 1);
    localparam logic [DRAIN_W-1:0] DRN_LAST = DRAIN_W'(DRN_LAST_I);
    localparam logic [CADDR_W:0]   NTAPS_X  = (CADDR_W + 1)'(NTAPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CADDR_W-1:0]  k_q, k_d;
    logic [DRAIN_W-1:0]  drn_q, drn_d;
    logic [DADDR_W-1:0]  wptr_q, wptr_d;
    logic [15:0]         din_q, din_d;
    logic                hwe_q, hwe_d;
    logic [CADDR_W-1:0]  haddr_q, haddr_d;
    logic [15:0]         hdata_q, hdata_d;
    logic                ovr_q, ovr_d;
    logic                cae_q, cae_d;

    logic                tick_acc;
    logic                host_acc;
    logic                caddr_ok;

    assign tick_acc = sample_tick & seq_en;
    // The sample always beats a host write arriving in the same idle cycle.
    assign host_acc = h_cvalid & (state_q == S_IDLE) & ~tick_acc & ~rst;
    assign caddr_ok = ({1'b0, h_caddr} < NTAPS_X);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            drn_q   <= '0;
            wptr_q  <= '0;
            din_q   <= '0;
            hwe_q   <= 1'b0;
            haddr_q <= '0;
            hdata_q <= '0;
            ovr_q   <= 1'b0;
            cae_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drn_q   <= drn_d;
            wptr_q  <= wptr_d;
            din_q   <= din_d;
            hwe_q   <= hwe_d;
            haddr_q <= haddr_d;
            hdata_q <= hdata_d;
            ovr_q   <= ovr_d;
            cae_q   <= cae_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drn_d   = drn_q;
        wptr_d  = wptr_q;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                if (tick_acc) begin
                    state_d = S_WRITE;
                    din_d   = din;
                end
            end
            S_WRITE: begin
                k_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    drn_d   = '0;
                    wptr_d  = wptr_q + 1'b1;
                    state_d = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Host write capture and sticky error flags; a set event beats err_clr.
    always_comb begin
        hwe_d   = host_acc & caddr_ok;
        haddr_d = host_acc ? h_caddr : haddr_q;
        hdata_d = host_acc ? h_cdata : hdata_q;

        ovr_d = ovr_q & ~err_clr;
        if (tick_acc && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        cae_d = cae_q & ~err_clr;
        if (host_acc && !caddr_ok) begin
            cae_d = 1'b1;
        end
    end

    // Output decode
    always_comb begin
        h_cready    = host_acc;
        busy        = (state_q != S_IDLE);
        overrun_err = ovr_q;
        caddr_err   = cae_q;

        cmem_we     = hwe_q;
        cmem_addr   = hwe_q ? haddr_q : '0;
        cmem_wdata  = hwe_q ? hdata_q : '0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        mac_last    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            S_WRITE: begin
                dmem_we    = 1'b1;
                dmem_addr  = wptr_q;
                dmem_wdata = din_q;
            end
            S_RUN: begin
                // Tap k reads the sample written k ticks ago.
                mac_en    = 1'b1;
                cmem_addr = k_q;
                dmem_addr = wptr_q - DADDR_W'(k_q);
                mac_clr   = (k_q == '0);
                mac_last  = (k_q == K_LAST);
            end
            S_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_w4823_fir_seq.sv
// Bench for w4823_fir_seq: a cycle-age model of each sweep and of pending host
// writes is compared against the DUT every cycle, plus directed literal checks.
module tb_w4823_fir_seq;

    localparam int NT       = 65;
    localparam int PL       = 4;
    localparam int RUN_END  = 1 + NT;
    localparam int DONE_AGE = 2 + NT + PL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seq_en = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] din = '0;
    logic        h_cvalid = 1'b0;
    logic [6:0]  h_caddr = '0;
    logic [15:0] h_cdata = '0;
    logic        h_cready;
    logic        err_clr = 1'b0;
    logic        cmem_we;
    logic [6:0]  cmem_addr;
    logic [15:0] cmem_wdata;
    logic        dmem_we;
    logic [6:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic        mac_en, mac_clr, mac_last, out_valid, busy, overrun_err, caddr_err;

    w4823_fir_seq dut (
        .clk(clk), .rst(rst), .seq_en(seq_en), .sample_tick(sample_tick), .din(din),
        .h_cvalid(h_cvalid), .h_caddr(h_caddr), .h_cdata(h_cdata), .h_cready(h_cready),
        .err_clr(err_clr), .cmem_we(cmem_we), .cmem_addr(cmem_addr), .cmem_wdata(cmem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .out_valid(out_valid),
        .busy(busy), .overrun_err(overrun_err), .caddr_err(caddr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: age of the running sweep (-1 idle, 1 = write cycle), write pointer, pending host write.
    int          m_age = -1;
    logic [6:0]  m_wptr = '0;
    logic [15:0] m_din = '0;
    logic        m_pwe = 1'b0;
    logic [6:0]  m_paddr = '0;
    logic [15:0] m_pdata = '0;
    logic        m_ovr = 1'b0;
    logic        m_cae = 1'b0;
    logic        m_init = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_age  <= -1;
            m_wptr <= '0;
            m_pwe  <= 1'b0;
            m_ovr  <= 1'b0;
            m_cae  <= 1'b0;
            m_init <= 1'b1;
        end else begin
            if (m_age >= 0) begin
                m_age <= (m_age == DONE_AGE) ? -1 : m_age + 1;
                if (m_age == RUN_END) m_wptr <= m_wptr + 7'd1;
            end else if (sample_tick && seq_en) begin
                m_age <= 1;
                m_din <= din;
            end
            m_pwe <= h_cvalid && (m_age < 0) && !(sample_tick && seq_en) && (h_caddr < 7'(NT));
            if (h_cvalid && (m_age < 0) && !(sample_tick && seq_en)) begin
                m_paddr <= h_caddr;
                m_pdata <= h_cdata;
            end
            if (sample_tick && seq_en && (m_age >= 0)) m_ovr <= 1'b1;
            else if (err_clr) m_ovr <= 1'b0;
            if (h_cvalid && (m_age < 0) && !(sample_tick && seq_en) && (h_caddr >= 7'(NT)))
                m_cae <= 1'b1;
            else if (err_clr) m_cae <= 1'b0;
        end
    end

    // Observed event log, used by the directed checks
    int         dwe_cyc = -1, clr_cyc = -1, last_cyc = -1, ov_cyc = -1;
    int         ov_cnt = 0, cwe_cnt = 0;
    logic [6:0] dwe_addr = '0, clr_daddr = '0, last_daddr = '0;

    always @(negedge clk) begin : cmp
        int   k;
        logic e_run;
        if (m_init && !rst) begin
            k     = m_age - 2;
            e_run = (m_age >= 2) && (m_age <= RUN_END);
            chk("busy", 32'(busy), 32'(m_age >= 0));
            chk("mac_en", 32'(mac_en), 32'(e_run));
            chk("mac_clr", 32'(mac_clr), 32'(e_run && k == 0));
            chk("mac_last", 32'(mac_last), 32'(e_run && k == NT - 1));
            chk("out_valid", 32'(out_valid), 32'(m_age == DONE_AGE));
            chk("dmem_we", 32'(dmem_we), 32'(m_age == 1));
            chk("cmem_we", 32'(cmem_we), 32'(m_pwe));
            chk("h_cready", 32'(h_cready),
                32'(h_cvalid && (m_age < 0) && !(sample_tick && seq_en)));
            chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
            chk("caddr_err", 32'(caddr_err), 32'(m_cae));
            if (m_age == 1) begin
                chk("dmem_waddr", 32'(dmem_addr), 32'(m_wptr));
                chk("dmem_wdata", 32'(dmem_wdata), 32'(m_din));
            end
            if (e_run) begin
                chk("run_cmem_addr", 32'(cmem_addr), 32'(k));
                chk("run_dmem_addr", 32'(dmem_addr), 32'(7'(m_wptr - 7'(k))));
            end
            if (m_pwe) begin
                chk("cmem_waddr", 32'(cmem_addr), 32'(m_paddr));
                chk("cmem_wdata", 32'(cmem_wdata), 32'(m_pdata));
            end
            if (dmem_we)   begin dwe_cyc = cyc; dwe_addr = dmem_addr; end
            if (mac_clr)   begin clr_cyc = cyc; clr_daddr = dmem_addr; end
            if (mac_last)  begin last_cyc = cyc; last_daddr = dmem_addr; end
            if (out_valid) begin ov_cyc = cyc; ov_cnt++; end
            if (cmem_we)   cwe_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic tick_now(input logic [15:0] d, output int t);
        sample_tick = 1'b1;
        din = d;
        t = cyc;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic host_wr(input logic [6:0] a, input logic [15:0] d);
        int n;
        n = 0;
        step();
        h_cvalid = 1'b1;
        h_caddr = a;
        h_cdata = d;
        @(negedge clk);
        while (!h_cready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!h_cready) begin
            errors++;
            $display("FAIL host_wr_timeout: got h_cready=0 expected 1 within 300 cycles");
        end
        step();
        h_cvalid = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mac_en"}, 32'(mac_en), 32'd0);
        chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_cmem_we"}, 32'(cmem_we), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
        chk({tag, "_caddr_err"}, 32'(caddr_err), 32'd0);
        chk({tag, "_dmem_addr"}, 32'(dmem_addr), 32'd0);
        chk({tag, "_cmem_addr"}, 32'(cmem_addr), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, n, acc, ov0, cw0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        all_zero("reset");

        // 1: load all coefficients
        for (int i = 0; i < NT; i++) host_wr(7'(i), 16'h3C00 + 16'(i));
        repeat (2) step();
        chk("t1_cmem_we_count", 32'(cwe_cnt), 32'd65);
        chk("t1_caddr_err", 32'(caddr_err), 32'd0);
        $display("T1 coefficient load: %0d writes", cwe_cnt);

        // 2: single sweep timing
        step();
        tick_now(16'h4000, t);
        go_to(t + 75);
        chk("t2_dwe_cyc", 32'(dwe_cyc), 32'(t + 1));
        chk("t2_dwe_addr", 32'(dwe_addr), 32'd0);
        chk("t2_clr_cyc", 32'(clr_cyc), 32'(t + 2));
        chk("t2_clr_daddr", 32'(clr_daddr), 32'd0);
        chk("t2_last_cyc", 32'(last_cyc), 32'(t + 66));
        chk("t2_last_daddr", 32'(last_daddr), 32'd64);
        chk("t2_ov_cyc", 32'(ov_cyc), 32'(t + 71));
        chk("t2_ov_cnt", 32'(ov_cnt), 32'd1);
        $display("T2 sweep: tick %0d out_valid %0d", t, ov_cyc);

        // 3: 130 ticks, delay-line pointer wraps
        for (int i = 0; i < 130; i++) begin
            step();
            tick_now(16'(16'h1000 + i), t);
            go_to(t + 255);
            chk("t3_dwe_addr", 32'(dwe_addr), 32'((i + 1) % 128));
            chk("t3_tap0_addr", 32'(clr_daddr), 32'((i + 1) % 128));
            $display("T3 tick %0d: write addr %0d", i, dwe_addr);
        end
        chk("t3_overrun", 32'(overrun_err), 32'd0);

        // 4: overrun during a sweep, then err_clr
        step();
        ov0 = ov_cnt;
        tick_now(16'h5555, t);
        go_to(t + 30);
        tick_now(16'h6666, t2);
        go_to(t + 80);
        chk("t4_ov_cyc", 32'(ov_cyc), 32'(t + 71));
        chk("t4_ov_cnt", 32'(ov_cnt), 32'(ov0 + 1));
        chk("t4_overrun_set", 32'(overrun_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_overrun_clr", 32'(overrun_err), 32'd0);
        $display("T4 overrun tick %0d dropped, flag cleared", t2);

        // seq_en=0: tick ignored without error
        step();
        seq_en = 1'b0;
        ov0 = ov_cnt;
        tick_now(16'h7777, t);
        go_to(t + 80);
        seq_en = 1'b1;
        chk("seq_dis_ov_cnt", 32'(ov_cnt), 32'(ov0));
        chk("seq_dis_overrun", 32'(overrun_err), 32'd0);
        $display("seq_en=0 tick at %0d ignored", t);

        // 5: sample beats host write, then out-of-range address
        step();
        cw0 = cwe_cnt;
        h_cvalid = 1'b1;
        h_caddr = 7'd5;
        h_cdata = 16'hABCD;
        sample_tick = 1'b1;
        din = 16'h4400;
        t = cyc;
        @(negedge clk);
        chk("t5_cready_blocked", 32'(h_cready), 32'd0);
        step();
        sample_tick = 1'b0;
        n = 0;
        @(negedge clk);
        while (!h_cready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        step();
        h_cvalid = 1'b0;
        chk("t5_accept_cyc", 32'(acc), 32'(t + 72));
        step();
        chk("t5_cwe_cnt", 32'(cwe_cnt), 32'(cw0 + 1));
        host_wr(7'd70, 16'hDEAD);
        repeat (2) step();
        chk("t5_caddr_err", 32'(caddr_err), 32'd1);
        chk("t5_cwe_cnt_drop", 32'(cwe_cnt), 32'(cw0 + 1));
        $display("T5 host write accepted at %0d, bad address flagged", acc);

        // 6: reset mid-sweep
        step();
        ov0 = ov_cnt;
        tick_now(16'h3800, t);
        go_to(t + 40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        all_zero("t6");
        go_to(t + 150);
        chk("t6_no_out_valid", 32'(ov_cnt), 32'(ov0));
        step();
        tick_now(16'h3A00, t2);
        go_to(t2 + 80);
        chk("t6_dwe_cyc", 32'(dwe_cyc), 32'(t2 + 1));
        chk("t6_dwe_addr", 32'(dwe_addr), 32'd0);
        $display("T6 reset at %0d, new write addr %0d", t + 40, dwe_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
